// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: streams an 8-word line from pipelined memory into the cache, then writes its tag
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] memory_address,
    output logic [15:0] cache_addr,
    output logic [15:0] data_out,
    output logic        write_data_array,
    output logic [7:0]  tag_out,
    output logic        write_tag_array,
    output logic        fill_done
);
    localparam int WORDS = 8;

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t      state, state_nxt;
    logic [3:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic [15:0] line_base;

    // state register plus request/response counters and the latched line address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            line_base <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss_detected) begin
                line_base <= miss_address & 16'hFFF0;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else if (state == FILL) begin
                if (mem_en) issue_cnt <= issue_cnt + 4'd1;
                if (memory_data_valid) recv_cnt <= recv_cnt + 3'd1;
            end
        end
    end

    // next state and outputs; word offsets are spliced into addr[3:1] so they never carry out of the line
    always_comb begin
        state_nxt        = state;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        cache_addr       = '0;
        data_out         = '0;
        write_data_array = 1'b0;
        tag_out          = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        case (state)
            IDLE: state_nxt = miss_detected ? FILL : IDLE;
            FILL: begin
                fsm_busy         = 1'b1;
                mem_en           = issue_cnt < 4'(WORDS);
                memory_address   = mem_en ? {line_base[15:4], issue_cnt[2:0], 1'b0} : 16'h0000;
                write_data_array = memory_data_valid;
                data_out         = memory_data_valid ? memory_data : 16'h0000;
                cache_addr       = memory_data_valid ? {line_base[15:4], recv_cnt, 1'b0} : line_base;
                state_nxt        = (memory_data_valid && recv_cnt == 3'(WORDS - 1)) ? TAG : FILL;
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                cache_addr      = line_base;
                fill_done       = 1'b1;
                tag_out         = {line_base[15:10], 1'b1, 1'b0};
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed fills against a 4-cycle in-order memory model
module tb_cache_fill_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] memory_data = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy, mem_en, write_data_array, write_tag_array, fill_done;
    logic [15:0] memory_address, cache_addr, data_out;
    logic [7:0]  tag_out;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [15:0] req_log[$];
    logic [15:0] wr_log[$];
    int          n_checks = 0, n_fail = 0, cyc = 0;
    int          tag_cnt, busy_cnt, done_cnt, beats;
    int          hole_after = -1, hole_left = 0;
    logic [7:0]  last_tag;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
        .mem_en(mem_en), .memory_address(memory_address), .cache_addr(cache_addr),
        .data_out(data_out), .write_data_array(write_data_array), .tag_out(tag_out),
        .write_tag_array(write_tag_array), .fill_done(fill_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {3'b000, fsm_busy, mem_en, memory_address, cache_addr, data_out,
                write_data_array, tag_out, write_tag_array, fill_done};
    endfunction

    task automatic clear_logs();
        req_log.delete();
        wr_log.delete();
        tag_cnt  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        beats    = 0;
        last_tag = '0;
    endtask

    // one clock: drive inputs at negedge, then observe and feed the memory model
    task automatic cycle(input logic miss, input logic [15:0] maddr, input logic extra);
        rsp_t r;
        @(negedge clk);
        miss_detected     = miss;
        miss_address      = maddr;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        if (beats == hole_after + 1 && hole_left > 0) hole_left--;
        else if (q.size() > 0 && q[0].due <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = q[0].data;
            void'(q.pop_front());
            beats++;
        end
        if (!memory_data_valid && extra) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end
        #1;
        if (mem_en) begin
            req_log.push_back(memory_address);
            r.due  = cyc + 4;
            r.data = memory_address ^ 16'h5A5A;
            q.push_back(r);
        end
        if (write_data_array) begin
            wr_log.push_back(cache_addr);
            check("wr_data", data_out, cache_addr ^ 16'h5A5A);
        end
        if (write_tag_array) begin
            tag_cnt++;
            last_tag = tag_out;
        end
        if (fsm_busy) busy_cnt++;
        if (fill_done) done_cnt++;
        cyc++;
    endtask

    task automatic do_fill(input logic [15:0] addr, input logic [15:0] base, input int exp_busy,
                           input logic pulse, input logic extra, input logic [7:0] exp_tag);
        int k;
        clear_logs();
        cycle(1'b1, addr, 1'b0);
        k = 0;
        while (done_cnt == 0 && k < 40) begin
            cycle(pulse && (k == 3 || k == 12), 16'hABC0, extra && k == 12);
            k++;
        end
        check("fill_done_seen", done_cnt, 1);
        check("busy_cycles", busy_cnt, exp_busy);
        check("tag_writes", tag_cnt, 1);
        check("tag_value", last_tag, exp_tag);
        check("req_count", req_log.size(), 8);
        check("wr_count", wr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("req_addr", (i < req_log.size()) ? req_log[i] : 16'h0001, base + 16'(2 * i));
            check("wr_addr", (i < wr_log.size()) ? wr_log[i] : 16'h0001, base + 16'(2 * i));
        end
    endtask

    initial begin
        clear_logs();
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 64'h0);
        rst_n = 1'b1;
        // basic fill
        do_fill(16'h1236, 16'h1230, 13, 1'b0, 1'b0, 8'h12);
        // 2-cycle response hole after beat 3
        hole_after = 3;
        hole_left  = 2;
        do_fill(16'h5678, 16'h5670, 15, 1'b0, 1'b0, 8'h56);
        hole_after = -1;
        // miss pulses while busy are ignored
        do_fill(16'h1230, 16'h1230, 13, 1'b1, 1'b0, 8'h12);
        clear_logs();
        repeat (4) cycle(1'b0, 16'hABC0, 1'b0);
        check("no_refill", req_log.size(), 0);
        check("idle_not_busy", busy_cnt, 0);
        // reset mid-fill
        clear_logs();
        cycle(1'b1, 16'h2468, 1'b0);
        for (int k = 0; k < 20 && wr_log.size() < 6; k++) cycle(1'b0, 16'hABC0, 1'b0);
        check("pre_rst_writes", wr_log.size(), 6);
        #1 rst_n = 1'b0;
        #1 check("rst_outs", outs(), 64'h0);
        q.delete();
        clear_logs();
        repeat (3) cycle(1'b0, 16'h0000, 1'b0);
        check("rst_no_tag", tag_cnt, 0);
        check("rst_not_busy", busy_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_fill(16'h4000, 16'h4000, 13, 1'b0, 1'b0, 8'h42);
        // stray valid in TAG and in IDLE
        do_fill(16'h0A10, 16'h0A10, 13, 1'b0, 1'b1, 8'h0A);
        clear_logs();
        cycle(1'b0, 16'h0000, 1'b1);
        check("idle_valid_ignored", wr_log.size(), 0);
        check("idle_valid_not_busy", busy_cnt, 0);
        // top-of-memory line, then back-to-back miss
        do_fill(16'hFFFE, 16'hFFF0, 13, 1'b0, 1'b0, 8'hFE);
        do_fill(16'h8888, 16'h8880, 13, 1'b0, 1'b0, 8'h8A);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
